// File: rtl/helios_pkg.sv
// Shared definitions for the Union-Find decoder vertex units: controller stage
// codes and the default vertex address width.
package helios_pkg;

  localparam int STAGE_WIDTH   = 3;
  localparam int ADDRESS_WIDTH = 15;

  localparam logic [STAGE_WIDTH-1:0] STAGE_IDLE                = 3'd0;
  localparam logic [STAGE_WIDTH-1:0] STAGE_GROW_BOUNDARY       = 3'd1;
  localparam logic [STAGE_WIDTH-1:0] STAGE_MERGE               = 3'd2;
  localparam logic [STAGE_WIDTH-1:0] STAGE_SYNC_IS_ODD_CLUSTER = 3'd3;
  localparam logic [STAGE_WIDTH-1:0] STAGE_MEASUREMENT_LOADING = 3'd4;

endpackage

// File: rtl/helios_processing_unit_min_root_tree.sv
// Combinational minimum over the valid entries of a packed address vector,
// built as a balanced binary tree; any_valid flags that at least one entry counted.
module min_root_tree #(
  parameter int N     = 4,
  parameter int WIDTH = 15
) (
  input  logic [N-1:0]       valid,
  input  logic [N*WIDTH-1:0] addr,
  output logic [WIDTH-1:0]   min_addr,
  output logic               any_valid
);

  if (N == 1) begin : g_leaf
    assign min_addr  = addr;
    assign any_valid = valid[0];
  end else begin : g_node
    localparam int NL = N / 2;
    localparam int NH = N - NL;

    logic [WIDTH-1:0] lo_min_s;
    logic [WIDTH-1:0] hi_min_s;
    logic             lo_valid_s;
    logic             hi_valid_s;

    min_root_tree #(.N(NL), .WIDTH(WIDTH)) u_lo (
      .valid     (valid[NL-1:0]),
      .addr      (addr[NL*WIDTH-1:0]),
      .min_addr  (lo_min_s),
      .any_valid (lo_valid_s)
    );

    min_root_tree #(.N(NH), .WIDTH(WIDTH)) u_hi (
      .valid     (valid[N-1:NL]),
      .addr      (addr[N*WIDTH-1:NL*WIDTH]),
      .min_addr  (hi_min_s),
      .any_valid (hi_valid_s)
    );

    // Pick the smaller half-result, ignoring a half with no valid entry.
    always_comb begin
      if (lo_valid_s && hi_valid_s) begin
        min_addr = (hi_min_s < lo_min_s) ? hi_min_s : lo_min_s;
      end else if (lo_valid_s) begin
        min_addr = lo_min_s;
      end else begin
        min_addr = hi_min_s;
      end
    end

    assign any_valid = lo_valid_s | hi_valid_s;
  end

endmodule

// File: rtl/helios_processing_unit.sv
// One Union-Find decoding-graph vertex: holds cluster root and odd flag, pulses
// link growth, merges by min-root propagation and reports busy for convergence.
module helios_processing_unit #(
  parameter int                       ADDRESS_WIDTH  = helios_pkg::ADDRESS_WIDTH,
  parameter int                       NEIGHBOR_COUNT = 4,
  parameter logic [ADDRESS_WIDTH-1:0] ADDRESS        = {ADDRESS_WIDTH{1'b0}},
  parameter int                       STAGE_WIDTH    = helios_pkg::STAGE_WIDTH
) (
  input  logic                                     clk,
  input  logic                                     reset_n,
  input  logic [STAGE_WIDTH-1:0]                   stage,
  input  logic                                     measurement,
  input  logic [NEIGHBOR_COUNT-1:0]                neighbor_fully_grown,
  input  logic [NEIGHBOR_COUNT*ADDRESS_WIDTH-1:0]  neighbor_old_root_in,
  input  logic [NEIGHBOR_COUNT-1:0]                neighbor_is_odd_cluster,
  output logic [NEIGHBOR_COUNT-1:0]                neighbor_increase,
  output logic [ADDRESS_WIDTH-1:0]                 old_root_out,
  output logic [ADDRESS_WIDTH-1:0]                 root,
  output logic                                     is_odd_cluster,
  output logic                                     busy
);

  import helios_pkg::*;

  logic [ADDRESS_WIDTH-1:0]  root_q, root_d;
  logic [ADDRESS_WIDTH-1:0]  old_root_q, old_root_d;
  logic                      odd_q, odd_d;
  logic                      parity_q, parity_d;
  logic [NEIGHBOR_COUNT-1:0] inc_q, inc_d;
  logic                      busy_q, busy_d;
  logic [STAGE_WIDTH-1:0]    prev_stage_q, prev_stage_d;

  logic [ADDRESS_WIDTH-1:0]  cand_s;
  logic                      cand_valid_s;
  logic                      stage_entry_s;
  logic                      sync_odd_s;

  min_root_tree #(.N(NEIGHBOR_COUNT), .WIDTH(ADDRESS_WIDTH)) u_min_root_tree (
    .valid     (neighbor_fully_grown),
    .addr      (neighbor_old_root_in),
    .min_addr  (cand_s),
    .any_valid (cand_valid_s)
  );

  assign stage_entry_s = (stage != prev_stage_q);
  // A vertex whose root is still itself carries its own syndrome parity into the cluster.
  assign sync_odd_s = (parity_q & (root_q == ADDRESS)) |
                      (|(neighbor_fully_grown & neighbor_is_odd_cluster));

  // Next-state logic for the selected controller stage; reserved codes behave as idle.
  always_comb begin
    root_d       = root_q;
    odd_d        = odd_q;
    parity_d     = parity_q;
    inc_d        = {NEIGHBOR_COUNT{1'b0}};
    busy_d       = 1'b0;
    old_root_d   = root_q;
    prev_stage_d = stage;
    case (stage)
      STAGE_WIDTH'(STAGE_MEASUREMENT_LOADING): begin
        root_d   = ADDRESS;
        parity_d = measurement;
        odd_d    = measurement;
      end
      STAGE_WIDTH'(STAGE_GROW_BOUNDARY): begin
        if (stage_entry_s) begin
          inc_d = {NEIGHBOR_COUNT{odd_q}} & ~neighbor_fully_grown;
        end else begin
          inc_d = {NEIGHBOR_COUNT{1'b0}};
        end
      end
      STAGE_WIDTH'(STAGE_MERGE): begin
        if (cand_valid_s && (cand_s < root_q)) begin
          root_d = cand_s;
          busy_d = 1'b1;
        end else begin
          busy_d = 1'b0;
        end
      end
      STAGE_WIDTH'(STAGE_SYNC_IS_ODD_CLUSTER): begin
        odd_d  = sync_odd_s;
        busy_d = (sync_odd_s != odd_q);
      end
      default: begin
        busy_d = 1'b0;
      end
    endcase
  end

  // State registers with asynchronous reset to the vertex's own address.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      root_q       <= ADDRESS;
      old_root_q   <= ADDRESS;
      odd_q        <= 1'b0;
      parity_q     <= 1'b0;
      inc_q        <= {NEIGHBOR_COUNT{1'b0}};
      busy_q       <= 1'b0;
      prev_stage_q <= STAGE_WIDTH'(STAGE_IDLE);
    end else begin
      root_q       <= root_d;
      old_root_q   <= old_root_d;
      odd_q        <= odd_d;
      parity_q     <= parity_d;
      inc_q        <= inc_d;
      busy_q       <= busy_d;
      prev_stage_q <= prev_stage_d;
    end
  end

  assign neighbor_increase = inc_q;
  assign old_root_out      = old_root_q;
  assign root              = root_q;
  assign is_odd_cluster    = odd_q;
  assign busy              = busy_q;

endmodule

// File: doc/helios_processing_unit.md
Name: helios_processing_unit

Overview:
- One decoding-graph vertex of the Union-Find decoder; N instances connect to the neighbour links on their incident edges.
- Holds the vertex's cluster root and odd-cluster flag.
- Drives its links' increase inputs during boundary growth.
- Merges clusters by min-root propagation over fully grown links and reports busy so the controller can detect convergence.

Parameters:
- ADDRESS_WIDTH, 15, width of a vertex address; must match the attached links.
- NEIGHBOR_COUNT, 4, number of incident links (1..8).
- ADDRESS, 0, this vertex's own address; its initial root.
- STAGE_WIDTH, 3, width of the controller stage code.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- stage  in  STAGE_WIDTH  global stage code from the controller
- measurement  in  1  syndrome bit for this vertex, sampled in MEASUREMENT_LOADING
- neighbor_fully_grown  in  NEIGHBOR_COUNT  per-link fully-grown flag
- neighbor_old_root_in  in  NEIGHBOR_COUNT*ADDRESS_WIDTH  registered root of the far vertex, per link (slice k = link k)
- neighbor_is_odd_cluster  in  NEIGHBOR_COUNT  per-link odd flag
- neighbor_increase  out  NEIGHBOR_COUNT  one-cycle grow pulse per link
- old_root_out  out  ADDRESS_WIDTH  this vertex's root, sent to every link
- root  out  ADDRESS_WIDTH  current cluster root
- is_odd_cluster  out  1  vertex belongs to an odd cluster
- busy  out  1  root or odd flag changed in the last cycle

Behaviour:
- Stage codes (shared package):
  - IDLE = 0
  - GROW_BOUNDARY = 1
  - MERGE = 2
  - SYNC_IS_ODD_CLUSTER = 3
  - MEASUREMENT_LOADING = 4
  - 5..7 reserved; treated as IDLE.
- Reset (reset_n low, asynchronous):
  - root = ADDRESS, old_root_out = ADDRESS
  - is_odd_cluster = 0, odd_parity = 0
  - neighbor_increase = 0, busy = 0
  - prev_stage = IDLE
- prev_stage is a register of stage; stage_entry = (stage != prev_stage).
- MEASUREMENT_LOADING, every cycle:
  - root <= ADDRESS; odd_parity <= measurement; is_odd_cluster <= measurement; busy <= 0.
- GROW_BOUNDARY:
  - On the stage_entry cycle only: neighbor_increase[k] <= is_odd_cluster & ~neighbor_fully_grown[k].
  - All other cycles: neighbor_increase = 0.
  - Net effect: exactly one registered pulse, 1 cycle after entry, per stage visit.
  - Holding GROW_BOUNDARY for many cycles must not re-pulse.
- MERGE, every cycle:
  - cand = min over all k with neighbor_fully_grown[k] of neighbor_old_root_in[k].
  - If any link is fully grown and cand < root: root <= cand, busy <= 1; else busy <= 0.
  - Ties and larger candidates leave root unchanged. Unsigned compare. Reduction is a combinational tree over NEIGHBOR_COUNT.
- SYNC_IS_ODD_CLUSTER, every cycle:
  - new = (odd_parity & (root == ADDRESS)) | OR_k(neighbor_fully_grown[k] & neighbor_is_odd_cluster[k]).
  - is_odd_cluster <= new; busy <= (new != is_odd_cluster).
- IDLE: all state holds; busy <= 0; neighbor_increase = 0.
- old_root_out <= root every cycle, one cycle behind root. The link adds one more register, so neighbour latency is 2 cycles per hop.
- Stage change mid-merge: no flush. Root persists until the next MEASUREMENT_LOADING.
- NEIGHBOR_COUNT = 1: min reduces to a single compare.

Decomposition:
- Package helios_pkg:
  - stage localparams STAGE_IDLE, STAGE_GROW_BOUNDARY, STAGE_MERGE, STAGE_SYNC_IS_ODD_CLUSTER, STAGE_MEASUREMENT_LOADING, and STAGE_WIDTH
  - shared ADDRESS_WIDTH default
- Sub-module min_root_tree (parameterised N, WIDTH):
  - inputs: valid vector and packed addresses
  - outputs: min address and any_valid
  - purely combinational; reused by the future boundary-vertex unit.

Test Plan:
- Reset: deassert reset_n with ADDRESS=5 -> root=5, old_root_out=5, is_odd_cluster=0, neighbor_increase=0, busy=0; asserting reset_n low mid-MERGE returns these values immediately, without waiting for a clock edge.
- Load and grow: measurement=1 in LOADING, then GROW held 4 cycles with fully_grown=4'b0010 -> neighbor_increase=4'b1101 for exactly one cycle (cycle after entry), 0 afterwards; with measurement=0 -> no pulses.
- Merge: ADDRESS=9, fully_grown=4'b0101, old_root_in = {k0:7, k1:2, k2:3, k3:8} -> root=3 next cycle, busy=1; next cycle busy=0; old_root_out=3 one cycle after root.
- Non-grown ignored / tie: root=4, only link 1 grown with old_root_in=4, link 0 (not grown) carries 1 -> root stays 4, busy=0.
- Sync odd: ADDRESS=6, root=6, odd_parity=1, no odd links -> is_odd_cluster=1; root=2 with link 3 grown & odd -> 1; root=2, no odd links -> 0, busy=1 on change.
- Reserved stage 7 after MERGE -> holds root, busy=0, no increases.
